video_mnist_seg_param_ctl: RTL and testbench

Frame-synchronous parameter controller for the MNIST segmentation video path. It owns the run-time settings of the pipeline: binarizer threshold and invert, the DNN blank count, and a pipeline enable. Settings are written through a Wishbone slave into shadow registers and copied to the live outputs only between frames. Frame boundaries are found by passively monitoring the binarizer's input AXI4-Stream handshake.

---
 rtl/video_mnist_seg_param_ctl.sv | 154 +++++++++++++++
 tb/tb_video_mnist_seg_param_ctl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_mnist_seg_param_ctl.sv
// Frame-synchronous run-time parameter controller: Wishbone shadow registers are copied to the
// live pipeline settings only between frames, found by snooping the binarizer stream handshake.
module video_mnist_seg_param_ctl #(
  parameter int unsigned           DATA_WIDTH           = 8,
  parameter int unsigned           IMG_Y_NUM            = 480,
  parameter int unsigned           IMG_Y_WIDTH          = 12,
  parameter int unsigned           TUSER_WIDTH          = 1,
  parameter int unsigned           WB_ADR_WIDTH         = 8,
  parameter int unsigned           WB_DAT_WIDTH         = 32,
  parameter int unsigned           WB_SEL_WIDTH         = WB_DAT_WIDTH / 8,
  parameter logic [31:0]           CORE_ID              = 32'h527a_2310,
  parameter logic [DATA_WIDTH-1:0] INIT_PARAM_TH        = DATA_WIDTH'(127),
  parameter logic                  INIT_PARAM_INV       = 1'b0,
  parameter logic [7:0]            INIT_PARAM_BLANK_NUM = 8'd30,
  parameter logic                  INIT_ENABLE          = 1'b1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic                    s_wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic                    s_wb_stb_i,
  output logic                    s_wb_ack_o,
  input  logic [TUSER_WIDTH-1:0]  s_axi4s_tuser,
  input  logic                    s_axi4s_tlast,
  input  logic                    s_axi4s_tvalid,
  input  logic                    s_axi4s_tready,
  output logic [DATA_WIDTH-1:0]   out_param_th,
  output logic                    out_param_inv,
  output logic [7:0]              out_param_blank_num,
  output logic                    out_enable,
  output logic                    out_in_frame,
  output logic                    out_frame_end
);

  localparam logic [WB_ADR_WIDTH-1:0] AdrCoreId   = WB_ADR_WIDTH'('h00);
  localparam logic [WB_ADR_WIDTH-1:0] AdrControl  = WB_ADR_WIDTH'('h04);
  localparam logic [WB_ADR_WIDTH-1:0] AdrStatus   = WB_ADR_WIDTH'('h05);
  localparam logic [WB_ADR_WIDTH-1:0] AdrFrameCnt = WB_ADR_WIDTH'('h06);
  localparam logic [WB_ADR_WIDTH-1:0] AdrThSh     = WB_ADR_WIDTH'('h08);
  localparam logic [WB_ADR_WIDTH-1:0] AdrInvSh    = WB_ADR_WIDTH'('h09);
  localparam logic [WB_ADR_WIDTH-1:0] AdrBlankSh  = WB_ADR_WIDTH'('h0A);
  localparam logic [WB_ADR_WIDTH-1:0] AdrTh       = WB_ADR_WIDTH'('h18);
  localparam logic [WB_ADR_WIDTH-1:0] AdrInv      = WB_ADR_WIDTH'('h19);
  localparam logic [WB_ADR_WIDTH-1:0] AdrBlank    = WB_ADR_WIDTH'('h1A);

  logic [DATA_WIDTH-1:0]   th_sh_q, th_q;
  logic [7:0]              blank_sh_q, blank_q;
  logic                    inv_sh_q, inv_q, en_sh_q, en_q;
  logic                    req_q, auto_q, in_frame_q, frame_end_q;
  logic [IMG_Y_WIDTH-1:0]  line_cnt_q;
  logic [31:0]             frame_cnt_q;

  logic                    hs, fs, le, fe, ap, apply, wr;
  logic [WB_DAT_WIDTH-1:0] wmask, rdata;

  assign hs    = s_axi4s_tvalid & s_axi4s_tready;
  assign fs    = hs & s_axi4s_tuser[0];
  assign le    = hs & s_axi4s_tlast;
  // A frame start in the same beat as a line end wins; that beat is never a frame end.
  assign fe    = le & ~fs & (line_cnt_q == IMG_Y_WIDTH'(IMG_Y_NUM - 1));
  assign ap    = fe | (~in_frame_q & ~fs);
  assign apply = ap & (req_q | auto_q);
  assign wr    = s_wb_stb_i & s_wb_we_i;

  always_comb begin
    wmask = '0;
    for (int i = 0; i < WB_SEL_WIDTH; i++) wmask[8*i +: 8] = {8{s_wb_sel_i[i]}};
  end

  function automatic logic [WB_DAT_WIDTH-1:0] merge(input logic [WB_DAT_WIDTH-1:0] old);
    return (old & ~wmask) | (s_wb_dat_i & wmask);
  endfunction

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      th_sh_q     <= INIT_PARAM_TH;
      inv_sh_q    <= INIT_PARAM_INV;
      blank_sh_q  <= INIT_PARAM_BLANK_NUM;
      en_sh_q     <= INIT_ENABLE;
      th_q        <= INIT_PARAM_TH;
      inv_q       <= INIT_PARAM_INV;
      blank_q     <= INIT_PARAM_BLANK_NUM;
      en_q        <= INIT_ENABLE;
      req_q       <= 1'b0;
      auto_q      <= 1'b0;
      in_frame_q  <= 1'b0;
      frame_end_q <= 1'b0;
      line_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (fs) begin
        in_frame_q <= 1'b1;
        line_cnt_q <= le ? IMG_Y_WIDTH'(1) : '0;
      end else if (fe) begin
        in_frame_q  <= 1'b0;
        line_cnt_q  <= '0;
        frame_cnt_q <= frame_cnt_q + 32'd1;
      end else if (le) begin
        line_cnt_q <= line_cnt_q + IMG_Y_WIDTH'(1);
      end
      frame_end_q <= fe;

      if (apply) begin
        th_q    <= th_sh_q;
        inv_q   <= inv_sh_q;
        blank_q <= blank_sh_q;
        en_q    <= en_sh_q;
        req_q   <= 1'b0;
      end

      // Register writes follow the apply so a request written on an apply edge survives it.
      if (wr) begin
        case (s_wb_adr_i)
          AdrControl: {auto_q, req_q, en_sh_q} <=
              3'(merge(WB_DAT_WIDTH'({auto_q, req_q & ~apply, en_sh_q})));
          AdrThSh:    th_sh_q    <= DATA_WIDTH'(merge(WB_DAT_WIDTH'(th_sh_q)));
          AdrInvSh:   inv_sh_q   <= 1'(merge(WB_DAT_WIDTH'(inv_sh_q)));
          AdrBlankSh: blank_sh_q <= 8'(merge(WB_DAT_WIDTH'(blank_sh_q)));
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (s_wb_adr_i)
      AdrCoreId:   rdata = WB_DAT_WIDTH'(CORE_ID);
      AdrControl:  rdata = WB_DAT_WIDTH'({auto_q, req_q, en_sh_q});
      AdrStatus:   rdata = WB_DAT_WIDTH'({in_frame_q, req_q, en_q});
      AdrFrameCnt: rdata = WB_DAT_WIDTH'(frame_cnt_q);
      AdrThSh:     rdata = WB_DAT_WIDTH'(th_sh_q);
      AdrInvSh:    rdata = WB_DAT_WIDTH'(inv_sh_q);
      AdrBlankSh:  rdata = WB_DAT_WIDTH'(blank_sh_q);
      AdrTh:       rdata = WB_DAT_WIDTH'(th_q);
      AdrInv:      rdata = WB_DAT_WIDTH'(inv_q);
      AdrBlank:    rdata = WB_DAT_WIDTH'(blank_q);
      default:     rdata = '0;
    endcase
  end

  assign s_wb_dat_o          = rdata;
  assign s_wb_ack_o          = s_wb_stb_i;
  assign out_param_th        = th_q;
  assign out_param_inv       = inv_q;
  assign out_param_blank_num = blank_q;
  assign out_enable          = en_q;
  assign out_in_frame        = in_frame_q;
  assign out_frame_end       = frame_end_q;

endmodule

// File: tb/tb_video_mnist_seg_param_ctl.sv
// Bench for video_mnist_seg_param_ctl: directed frame scenarios then random traffic, every cycle
// scored against a register/frame model through an expectation queue.
module tb_video_mnist_seg_param_ctl;

  localparam int Lines = 4;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [7:0]  adr;
  logic [31:0] dat_i, dat_o;
  logic        we, stb, ack;
  logic [3:0]  sel;
  logic [0:0]  tuser;
  logic        tlast, tvalid, tready;
  logic [7:0]  th, blank;
  logic        inv, en, in_frame, frame_end;

  always #5 clk = ~clk;

  video_mnist_seg_param_ctl #(.IMG_Y_NUM(Lines)) dut (
    .aclk(clk), .aresetn(aresetn),
    .s_wb_adr_i(adr), .s_wb_dat_i(dat_i), .s_wb_dat_o(dat_o), .s_wb_we_i(we),
    .s_wb_sel_i(sel), .s_wb_stb_i(stb), .s_wb_ack_o(ack),
    .s_axi4s_tuser(tuser), .s_axi4s_tlast(tlast), .s_axi4s_tvalid(tvalid),
    .s_axi4s_tready(tready),
    .out_param_th(th), .out_param_inv(inv), .out_param_blank_num(blank), .out_enable(en),
    .out_in_frame(in_frame), .out_frame_end(frame_end)
  );

  typedef struct {
    logic [7:0]  th;
    logic        inv;
    logic [7:0]  blank;
    logic        en;
    logic        in_frame;
    logic        fend;
    logic        stb;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // Reference model state: live settings, shadows, control flags, frame bookkeeping.
  logic [7:0]  m_th, m_blank, s_th, s_blank;
  logic        m_inv, m_en, s_inv, s_en, m_req, m_auto, m_inf, m_fend;
  int          m_lines;
  logic [31:0] m_fcnt;

  logic [7:0] adrs [12] = '{8'h00, 8'h04, 8'h05, 8'h06, 8'h08, 8'h09, 8'h0A,
                            8'h18, 8'h19, 8'h1A, 8'h07, 8'h04};

  function automatic void model_reset();
    m_th = 8'd127; m_inv = 1'b0; m_blank = 8'd30; m_en = 1'b1;
    s_th = 8'd127; s_inv = 1'b0; s_blank = 8'd30; s_en = 1'b1;
    m_req = 1'b0; m_auto = 1'b0; m_inf = 1'b0; m_fend = 1'b0;
    m_lines = 0; m_fcnt = 32'd0;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a)
      8'h00: return 32'h527a_2310;
      8'h04: return {29'd0, m_auto, m_req, s_en};
      8'h05: return {29'd0, m_inf, m_req, m_en};
      8'h06: return m_fcnt;
      8'h08: return {24'd0, s_th};
      8'h09: return {31'd0, s_inv};
      8'h0A: return {24'd0, s_blank};
      8'h18: return {24'd0, m_th};
      8'h19: return {31'd0, m_inv};
      8'h1A: return {24'd0, m_blank};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic void model_step(input bit rst, input bit v, input bit r, input bit u,
                                     input bit l, input bit st, input bit w,
                                     input logic [7:0] a, input logic [31:0] d,
                                     input logic [3:0] s);
    bit fs, le, fe, ap;
    logic [31:0] x;
    if (rst) begin
      model_reset();
      return;
    end
    fs = v && r && u;
    le = v && r && l;
    fe = le && !fs && (m_lines == Lines - 1);
    ap = fe || (!m_inf && !fs);
    m_fend = fe;
    if (fs) begin
      m_inf = 1'b1;
      m_lines = le ? 1 : 0;
    end else if (fe) begin
      m_inf = 1'b0;
      m_lines = 0;
      m_fcnt = m_fcnt + 32'd1;
    end else if (le) begin
      m_lines = (m_lines + 1) % 4096;
    end
    if (ap && (m_req || m_auto)) begin
      m_th = s_th; m_inv = s_inv; m_blank = s_blank; m_en = s_en;
      m_req = 1'b0;
    end
    if (st && w) begin
      case (a)
        8'h04: begin
          x = wmerge({29'd0, m_auto, m_req, s_en}, d, s);
          s_en = x[0]; m_req = x[1]; m_auto = x[2];
        end
        8'h08: begin x = wmerge({24'd0, s_th}, d, s);    s_th = x[7:0];    end
        8'h09: begin x = wmerge({31'd0, s_inv}, d, s);   s_inv = x[0];     end
        8'h0A: begin x = wmerge({24'd0, s_blank}, d, s); s_blank = x[7:0]; end
        default: ;
      endcase
    end
  endfunction

  // One clock cycle: drive, queue the expectation for this cycle, then advance the model.
  task automatic cycle(input bit rst, input bit v, input bit r, input bit u, input bit l,
                       input bit st, input bit w, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    aresetn = !rst; tvalid = v; tready = r; tuser = u; tlast = l;
    stb = st; we = w; adr = a; dat_i = d; sel = s;
    e.th = m_th; e.inv = m_inv; e.blank = m_blank; e.en = m_en;
    e.in_frame = m_inf; e.fend = m_fend; e.stb = st; e.rdata = model_read(a);
    sb.push_back(e);
    @(posedge clk);
    model_step(rst, v, r, u, l, st, w, a, d, s);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0, 0, 0, 8'h00, 32'd0, 4'h0);
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cycle(0, 0, 0, 0, 0, 1, 1, a, d, 4'hF);
  endtask
  task automatic rd(input logic [7:0] a);
    cycle(0, 0, 0, 0, 0, 1, 0, a, 32'd0, 4'h0);
  endtask
  task automatic bt(input bit u, input bit l);
    cycle(0, 1, 1, u, l, 0, 0, 8'h00, 32'd0, 4'h0);
  endtask
  task automatic bt_wr(input bit u, input bit l, input logic [7:0] a, input logic [31:0] d);
    cycle(0, 1, 1, u, l, 1, 1, a, d, 4'hF);
  endtask

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, req);
    end
  endfunction

  exp_t me;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      chk("out_param_th", {24'd0, th}, {24'd0, me.th});
      chk("out_param_inv", {31'd0, inv}, {31'd0, me.inv});
      chk("out_param_blank_num", {24'd0, blank}, {24'd0, me.blank});
      chk("out_enable", {31'd0, en}, {31'd0, me.en});
      chk("out_in_frame", {31'd0, in_frame}, {31'd0, me.in_frame});
      chk("out_frame_end", {31'd0, frame_end}, {31'd0, me.fend});
      chk("wb_ack", {31'd0, ack}, {31'd0, me.stb});
      if (me.stb) chk($sformatf("wb_rdata[%0h]", adr), dat_o, me.rdata);
    end
  end

  initial begin
    aresetn = 1'b0; tvalid = 0; tready = 0; tuser = 0; tlast = 0;
    stb = 0; we = 0; adr = 0; dat_i = 0; sel = 0;
    @(posedge clk);
    model_reset();
    #1;
    cycle(1, 0, 0, 0, 0, 0, 0, 8'h00, 32'd0, 4'h0);
    idle(2); rd(8'h00); rd(8'h18); rd(8'h05); rd(8'h04); rd(8'h30);

    // Idle-stream update
    wr(8'h08, 32'h40); wr(8'h04, 32'h2); idle(2); rd(8'h05); rd(8'h18); wr(8'h04, 32'h1);
    wr(8'h04, 32'h3); idle(1);

    // Mid-frame request waits for the frame end
    bt(1, 0); bt_wr(0, 0, 8'h08, 32'h80); bt_wr(0, 1, 8'h04, 32'h3); bt(0, 1); idle(1);
    bt(0, 1); bt(0, 1); idle(2); rd(8'h06); rd(8'h05); rd(8'h18);

    // Auto-update over three frames
    wr(8'h04, 32'h5);
    for (int f = 0; f < 3; f++) begin
      bt(1, 0); bt_wr(0, 1, 8'h08, 32'h10 * (f + 1)); bt(0, 1); bt(0, 1); bt(0, 1); idle(1);
    end
    wr(8'h04, 32'h1);

    // Short frame resynced by a second frame start
    wr(8'h08, 32'h5A); bt(1, 0); bt_wr(0, 1, 8'h04, 32'h3); bt(0, 1); bt(1, 0);
    repeat (4) bt(0, 1);
    idle(2); rd(8'h06); rd(8'h18);

    // Request rewritten on the frame-end edge
    bt(1, 0); bt_wr(0, 1, 8'h08, 32'h22); bt_wr(0, 1, 8'h04, 32'h3); bt(0, 1);
    bt_wr(0, 1, 8'h04, 32'h3); rd(8'h05); wr(8'h08, 32'h33); rd(8'h05); rd(8'h18);

    // Reset mid-frame with an update pending
    wr(8'h09, 32'h1); bt(1, 0); bt_wr(0, 1, 8'h04, 32'h3); bt(0, 1);
    cycle(1, 0, 0, 0, 0, 0, 0, 8'h00, 32'd0, 4'h0);
    cycle(1, 0, 0, 0, 0, 0, 0, 8'h00, 32'd0, 4'h0);
    idle(2); rd(8'h05); rd(8'h18); rd(8'h09);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit rst, st;
      rst = ($urandom_range(0, 599) == 0);
      st = !rst && ($urandom_range(0, 2) == 0);
      cycle(rst, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
            $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0,
            st, st && $urandom_range(0, 1) == 1, adrs[$urandom_range(0, 11)],
            $urandom, 4'($urandom_range(0, 15)));
    end

    idle(2);
    repeat (5) if (sb.size() > 0) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
